// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, commits datapath next_address,
// run/step/pause control, halt-instruction stop, retired counter.
// Ports: clk, reset_n (async, active low), start, step, halt_req,
//   next_address[7:0], im_out[7:0] in; pc_out[7:0], busy, halted,
//   timeout, retired[15:0], state[1:0] (IDLE=0 RUN=1 STEP=2 HALT=3) out.
// Optional: define PCSEQ_WATCHDOG_EN to add the self-loop watchdog.
module pc_sequencer #(
   parameter logic [7:0] RESET_PC   = 8'h00,
   parameter logic [7:0] HALT_INSTR = 8'hFF
`ifdef PCSEQ_WATCHDOG_EN
   ,
   parameter logic [7:0] LOOP_LIMIT = 8'd16
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        step,
   input  logic        halt_req,
   input  logic [7:0]  next_address,
   input  logic [7:0]  im_out,
   output logic [7:0]  pc_out,
   output logic        busy,
   output logic        halted,
   output logic        timeout,
   output logic [15:0] retired,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t      st_q, st_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] ret_q, ret_d;
   logic        busy_q, halted_q;
   logic        commit;
   logic        restart;
   logic        is_halt;
   logic        wd_trip;

   assign is_halt = (im_out == HALT_INSTR);

   always_comb begin
      st_d    = st_q;
      pc_d    = pc_q;
      ret_d   = ret_q;
      commit  = 1'b0;
      restart = 1'b0;
      unique case (st_q)
         S_IDLE: begin
            if (start)
               st_d = S_RUN;
            else if (step)
               st_d = S_STEP;
         end
         S_RUN: begin
            if (is_halt)
               st_d = S_HALT;
            else if (wd_trip)
               st_d = S_HALT;
            else begin
               commit = 1'b1;
               if (halt_req)
                  st_d = S_IDLE;
            end
         end
         S_STEP: begin
            if (is_halt)
               st_d = S_HALT;
            else begin
               commit = 1'b1;
               st_d   = S_IDLE;
            end
         end
         S_HALT: begin
            if (start) begin
               restart = 1'b1;
               st_d    = S_RUN;
            end
         end
         default: st_d = S_IDLE;
      endcase
      if (commit) begin
         pc_d = next_address;
         if (ret_q != 16'hFFFF)
            ret_d = ret_q + 16'd1;
      end
      if (restart) begin
         pc_d  = RESET_PC;
         ret_d = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q     <= S_IDLE;
         pc_q     <= RESET_PC;
         ret_q    <= 16'd0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         pc_q     <= pc_d;
         ret_q    <= ret_d;
         busy_q   <= (st_d == S_RUN) || (st_d == S_STEP);
         halted_q <= (st_d == S_HALT);
      end
   end

`ifdef PCSEQ_WATCHDOG_EN
   logic [7:0] wd_q, wd_d;
   logic       to_q, to_d;
   logic       self_loop;

   assign self_loop = (next_address == pc_q);
   assign wd_trip   = (wd_q >= LOOP_LIMIT);

   // Only RUN commits count toward a loop; STEP commits clear it.
   always_comb begin
      wd_d = wd_q;
      to_d = to_q;
      if (restart) begin
         wd_d = 8'd0;
         to_d = 1'b0;
      end else if (commit) begin
         if ((st_q == S_RUN) && self_loop)
            wd_d = wd_q + 8'd1;
         else
            wd_d = 8'd0;
      end else if ((st_q == S_RUN) && !is_halt && wd_trip) begin
         to_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_q <= 8'd0;
         to_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         to_q <= to_d;
      end
   end

   assign timeout = to_q;
`else
   assign wd_trip = 1'b0;
   assign timeout = 1'b0;
`endif

   assign pc_out  = pc_q;
   assign retired = ret_q;
   assign busy    = busy_q;
   assign halted  = halted_q;
   assign state   = st_q;

endmodule
